// File: rtl/knock_unlock_fsm_if.sv
// Cartridge-side bus bundle for the knock detector: qualified-access inputs
// plus the unlock/status outputs.
interface knock_unlock_fsm_if #(
  parameter int ADDR_W  = 14,
  parameter int KEY_LEN = 4
);
  localparam int SW = $clog2(KEY_LEN + 1);

  logic              sser_n;
  logic              bus_stb;
  logic [ADDR_W-1:0] ba;
  logic              br_w;
  logic              unlocked;
  logic [SW-1:0]     step;
  logic              fail_evt;
  logic              locked_out;
  logic              sdrd;
  logic              sdrd_oe;

  modport master (
    output sser_n, bus_stb, ba, br_w,
    input  unlocked, step, fail_evt, locked_out, sdrd, sdrd_oe
  );

  modport slave (
    input  sser_n, bus_stb, ba, br_w,
    output unlocked, step, fail_evt, locked_out, sdrd, sdrd_oe
  );
endinterface

// File: rtl/knock_unlock_fsm.sv
// Bus knock detector: walks a programmable nibble key on qualified window reads.
// Define KNOCK_LOCKOUT_EN to add the brute-force lockout state.
module knock_unlock_fsm #(
  parameter int                ADDR_W     = 14,
  parameter logic [ADDR_W-1:0] WIN_MASK   = 14'h3000,
  parameter logic [ADDR_W-1:0] WIN_BASE   = 14'h1000,
  parameter int                KEY_LSB    = 4,
  parameter int                KEY_LEN    = 4,
  parameter logic [63:0]       KEY        = 64'hC3A5,
  parameter logic [3:0]        RELOCK_NIB = 4'hF,
  parameter int                TIMEOUT    = 255,
  parameter int                MAX_FAIL   = 3,
  parameter int                LOCK_CYC   = 1023
) (
  input  logic               clk,
  input  logic               rst,
  knock_unlock_fsm_if.slave  bus
);
  localparam int SW  = $clog2(KEY_LEN + 1);
  localparam int KIW = $clog2(KEY_LEN);
  localparam int TW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_SEEK,
    S_UNLOCKED
`ifdef KNOCK_LOCKOUT_EN
    , S_LOCKOUT
`endif
  } state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] step, step_nxt;
  logic [TW-1:0] tmr, tmr_nxt;
  logic          fail, fail_q, unl_q, lko_q;
  logic          q;
  logic [3:0]    nib;

  logic [KEY_LEN-1:0][3:0] key_tab;
  for (genvar k = 0; k < KEY_LEN; k++) begin : g_key
    assign key_tab[k] = KEY[4*k +: 4];
  end

  assign q   = bus.bus_stb & ~bus.sser_n & ((bus.ba & WIN_MASK) == WIN_BASE);
  assign nib = bus.ba[KEY_LSB +: 4];

`ifdef KNOCK_LOCKOUT_EN
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int LW = $clog2(LOCK_CYC + 1);
  logic [FW-1:0] fcnt, fcnt_nxt;
  logic [LW-1:0] lcnt, lcnt_nxt;
`endif

  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    tmr_nxt   = tmr;
    fail      = 1'b0;
`ifdef KNOCK_LOCKOUT_EN
    fcnt_nxt  = fcnt;
    lcnt_nxt  = lcnt;
`endif
    case (state)
      S_SEEK: begin
        if (q) begin
          tmr_nxt = '0;
          if (!bus.br_w) begin
            step_nxt = '0;
            fail     = (step != '0);
          end else if (nib == key_tab[step[KIW-1:0]]) begin
            step_nxt = step + SW'(1);
            if (step_nxt == SW'(KEY_LEN)) state_nxt = S_UNLOCKED;
          end else begin
            // a wrong nibble that happens to be the first key nibble restarts at step 1
            step_nxt = (nib == key_tab[0]) ? SW'(1) : '0;
            fail     = (step != '0);
          end
        end else if (step != '0 && TIMEOUT != 0) begin
          if (tmr == TW'(TIMEOUT - 1)) begin
            step_nxt = '0;
            tmr_nxt  = '0;
            fail     = 1'b1;
          end else begin
            tmr_nxt = tmr + TW'(1);
          end
        end
      end
      S_UNLOCKED: begin
        if (q && !bus.br_w && nib == RELOCK_NIB) begin
          state_nxt = S_SEEK;
          step_nxt  = '0;
        end
      end
`ifdef KNOCK_LOCKOUT_EN
      S_LOCKOUT: begin
        step_nxt = '0;
        if (lcnt == LW'(LOCK_CYC - 1)) begin
          state_nxt = S_SEEK;
          lcnt_nxt  = '0;
          fcnt_nxt  = '0;
        end else begin
          lcnt_nxt = lcnt + LW'(1);
        end
      end
`endif
      default: begin
        state_nxt = S_SEEK;
        step_nxt  = '0;
      end
    endcase
`ifdef KNOCK_LOCKOUT_EN
    if (state_nxt == S_UNLOCKED) fcnt_nxt = '0;
    if (fail) begin
      if (fcnt != FW'(MAX_FAIL)) fcnt_nxt = fcnt + FW'(1);
      if (fcnt_nxt == FW'(MAX_FAIL)) begin
        state_nxt = S_LOCKOUT;
        step_nxt  = '0;
        tmr_nxt   = '0;
        lcnt_nxt  = '0;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_SEEK;
      step   <= '0;
      tmr    <= '0;
      fail_q <= 1'b0;
      unl_q  <= 1'b0;
      lko_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      step   <= step_nxt;
      tmr    <= tmr_nxt;
      fail_q <= fail;
      unl_q  <= (state_nxt == S_UNLOCKED);
`ifdef KNOCK_LOCKOUT_EN
      lko_q  <= (state_nxt == S_LOCKOUT);
`else
      lko_q  <= 1'b0;
`endif
    end
  end

`ifdef KNOCK_LOCKOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt <= '0;
      lcnt <= '0;
    end else begin
      fcnt <= fcnt_nxt;
      lcnt <= lcnt_nxt;
    end
  end
`endif

  assign bus.unlocked   = unl_q;
  assign bus.step       = step;
  assign bus.fail_evt   = fail_q;
  assign bus.locked_out = lko_q;
  assign bus.sdrd       = unl_q;
  assign bus.sdrd_oe    = q & bus.br_w;
endmodule

// File: tb/tb_knock_unlock_fsm.sv
// Scoreboard bench for knock_unlock_fsm: driver pushes model predictions,
// monitor pops and compares one cycle later.
module tb_knock_unlock_fsm;
  localparam int LOCK_CYC = 1023;
  localparam int TIMEOUT  = 255;
  localparam int MAX_FAIL = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  knock_unlock_fsm_if #(.ADDR_W(14), .KEY_LEN(4)) bif ();
  knock_unlock_fsm dut (.clk(clk), .rst(rst), .bus(bif));

  typedef struct {
    logic       unl;
    logic [2:0] st;
    logic       fe;
    logic       lo;
    logic       oe;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model: progress through the key as plain integers
  int key[4] = '{5, 10, 3, 12};
  int prog, idle, fails, lock_left;
  bit unl;

  task automatic chk(string nm, logic [15:0] act, logic [15:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h @%0t", nm, act, want, $time);
    end
  endtask

  function automatic void model_reset();
    prog = 0; idle = 0; fails = 0; lock_left = 0; unl = 0;
  endfunction

  function automatic void model(bit stb, bit sn, logic [13:0] a, bit rd, output exp_t e);
    bit q  = stb && !sn && (a[13:12] == 2'b01);
    int n  = int'(a[7:4]);
    bit fe = 0;
    e.oe = q && rd;
    if (lock_left > 0) begin
      lock_left--;
      if (lock_left == 0) begin prog = 0; fails = 0; end
    end else if (unl) begin
      if (q && !rd && n == 15) begin unl = 0; prog = 0; end
    end else begin
      if (q) begin
        idle = 0;
        if (!rd) begin fe = (prog > 0); prog = 0; end
        else if (n == key[prog]) begin
          prog++;
          if (prog == 4) begin unl = 1; fails = 0; end
        end else begin
          fe = (prog > 0);
          prog = (n == key[0]) ? 1 : 0;
        end
      end else if (prog > 0) begin
        idle++;
        if (idle == TIMEOUT) begin idle = 0; prog = 0; fe = 1; end
      end
      if (fe) begin
        fails++;
`ifdef KNOCK_LOCKOUT_EN
        if (fails >= MAX_FAIL) begin lock_left = LOCK_CYC; prog = 0; idle = 0; end
`endif
      end
    end
    e.unl = unl;
    e.st  = 3'(prog);
    e.fe  = fe;
    e.lo  = (lock_left > 0);
  endfunction

  task automatic cyc(bit stb, bit sn, logic [13:0] a, bit rd);
    exp_t e;
    @(negedge clk);
    bif.bus_stb = stb; bif.sser_n = sn; bif.ba = a; bif.br_w = rd;
    model(stb, sn, a, rd, e);
    exp_q.push_back(e);
  endtask

  task automatic rd_(logic [13:0] a); cyc(1, 0, a, 1); endtask
  task automatic wr_(logic [13:0] a); cyc(1, 0, a, 0); endtask
  task automatic idle_(int n); for (int i = 0; i < n; i++) cyc(0, 1, 14'h0, 1); endtask
  task automatic key_(); rd_(14'h1050); rd_(14'h10A0); rd_(14'h1030); rd_(14'h10C0); endtask

  // asynchronous reset: outputs must clear without a clock edge
  task automatic arst(string nm);
    @(negedge clk);
    bif.bus_stb = 0; bif.sser_n = 1; bif.br_w = 1;
    #2 rst = 1;
    #1;
    chk({nm, "_step"}, 16'(bif.step), 0);
    chk({nm, "_unl"}, 16'(bif.unlocked), 0);
    chk({nm, "_lo"}, 16'(bif.locked_out), 0);
    chk({nm, "_sdrd"}, 16'(bif.sdrd), 0);
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("unlocked", 16'(bif.unlocked), 16'(e.unl));
        chk("step", 16'(bif.step), 16'(e.st));
        chk("fail_evt", 16'(bif.fail_evt), 16'(e.fe));
        chk("locked_out", 16'(bif.locked_out), 16'(e.lo));
        chk("sdrd", 16'(bif.sdrd), 16'(e.unl));
        chk("sdrd_oe", 16'(bif.sdrd_oe), 16'(e.oe));
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : driver
    logic [13:0] a;
    int nib;
    bif.bus_stb = 0; bif.sser_n = 1; bif.ba = '0; bif.br_w = 1;
    model_reset();
    #12;
    chk("rst_step", 16'(bif.step), 0);
    chk("rst_unl", 16'(bif.unlocked), 0);
    chk("rst_fe", 16'(bif.fail_evt), 0);
    chk("rst_lo", 16'(bif.locked_out), 0);
    chk("rst_oe", 16'(bif.sdrd_oe), 0);
    @(negedge clk);
    rst = 0;

    // straight unlock, ignored writes/reads, relock
    key_();
    wr_(14'h1070); rd_(14'h3050); rd_(14'h1050); wr_(14'h10F0); idle_(2);

    // wrong third nibble restarts at step 1 then completes
    arst("a0");
    rd_(14'h1050); rd_(14'h10A0); rd_(14'h1050);
    rd_(14'h10A0); rd_(14'h1030); rd_(14'h10C0); wr_(14'h10F0);

    // timeout exactly at TIMEOUT idle cycles; access on the last cycle wins
    arst("a1");
    rd_(14'h1050); idle_(TIMEOUT); idle_(2);
    rd_(14'h1050); idle_(TIMEOUT - 1); rd_(14'h10A0); idle_(3);

    // non-qualified accesses never move the step; write while seeking fails
    arst("a2");
    rd_(14'h1050); rd_(14'h3050); cyc(1, 1, 14'h10A0, 1); cyc(0, 0, 14'h10A0, 1);
    rd_(14'h10A0); wr_(14'h1030); idle_(2);

    // repeated failures: lockout build ignores the key for LOCK_CYC cycles
    arst("a3");
    for (int i = 0; i < MAX_FAIL; i++) begin rd_(14'h1050); wr_(14'h1000); end
    key_();
    idle_(LOCK_CYC);
    key_(); idle_(2);

    // async reset mid-sequence and while unlocked
    arst("a4");
    rd_(14'h1050); rd_(14'h10A0); rd_(14'h1030);
    arst("a5");
    key_();
    arst("a6");

    // randomized traffic biased toward key nibbles
    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: nib = key[(prog < 4) ? prog : 0];
        6:                nib = key[0];
        7:                nib = 15;
        default:          nib = int'($urandom_range(0, 15));
      endcase
      a = 14'($urandom());
      a[7:4] = 4'(nib);
      a[13:12] = ($urandom_range(0, 9) < 8) ? 2'b01 : 2'($urandom_range(2, 3));
      cyc($urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0, a,
          $urandom_range(0, 9) < 8);
    end
    idle_(1);
    @(posedge clk);
    #2;
    chk("drain", 16'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
